kat_iic_slave: RTL and testbench

I2C (IIC) responder (slave) that answers a bus master such as kat_iic_controller. It oversamples SCL/SDA on the core clock, detects START/STOP and matches a 7-bit address. Write bytes are delivered to the fabric as single-cycle pulses; read bytes are taken from a fabric-supplied data port. It drives SDA open-drain through an o/t pair, and never stretches SCL.

---
 rtl/kat_iic_slave_if.sv | 27 ++
 rtl/kat_iic_slave.sv | 193 +++++++++++++++++++
 tb/tb_kat_iic_slave.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/kat_iic_slave_if.sv
// kat_iic_slave_if: pad-side SCL/SDA and fabric-side byte
// handshake of the I2C responder.
interface kat_iic_slave_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       sda_t;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic [7:0] tx_data;
  logic       tx_taken;
  logic       busy;
  logic       stop_det;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_o, sda_t, rx_data, rx_valid,
    output rx_first, tx_taken, busy, stop_det
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_o, sda_t, rx_data, rx_valid,
    input  rx_first, tx_taken, busy, stop_det
  );
endinterface

// File: rtl/kat_iic_slave.sv
// kat_iic_slave: oversampling I2C responder, 7-bit address,
// open-drain SDA, never stretches SCL.
module kat_iic_slave #(
  parameter logic [6:0] IIC_ADDR    = 7'h29,
  parameter int         SYNC_STAGES = 2
) (
  input logic            OPB_Clk,
  input logic            OPB_Rst,
  kat_iic_slave_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA,
    WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl, sda, scl_z, sda_z;
  logic scl_rise, scl_fall, start, stop;

  logic [7:0] shift, shift_n;
  logic [2:0] cnt, cnt_n;
  logic full, full_n;
  logic rnw, rnw_n;
  logic first, first_n;

  logic       sda_t, sda_t_n;
  logic [7:0] rx_data, rx_data_n;
  logic       rx_valid, rx_valid_n;
  logic       rx_first, rx_first_n;
  logic       tx_taken, tx_taken_n;
  logic       busy, busy_n;
  logic       stop_det, stop_det_n;

  // Flops reset to 1 so an idle bus never looks like an edge.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_z    <= 1'b1;
      sda_z    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_z    <= scl;
      sda_z    <= sda;
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_z;
  assign scl_fall = ~scl & scl_z;
  assign start    = scl & scl_z & sda_z & ~sda;
  assign stop     = scl & scl_z & ~sda_z & sda;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state    <= IDLE;
      shift    <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      rnw      <= 1'b0;
      first    <= 1'b0;
      sda_t    <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      tx_taken <= 1'b0;
      busy     <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      cnt      <= cnt_n;
      full     <= full_n;
      rnw      <= rnw_n;
      first    <= first_n;
      sda_t    <= sda_t_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      rx_first <= rx_first_n;
      tx_taken <= tx_taken_n;
      busy     <= busy_n;
      stop_det <= stop_det_n;
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    cnt_n      = cnt;
    full_n     = full;
    rnw_n      = rnw;
    first_n    = first;
    sda_t_n    = sda_t;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rx_first_n = 1'b0;
    tx_taken_n = 1'b0;
    busy_n     = busy;
    stop_det_n = 1'b0;

    if (stop) begin
      state_n    = IDLE;
      sda_t_n    = 1'b1;
      busy_n     = 1'b0;
      stop_det_n = 1'b1;
      cnt_n      = '0;
      full_n     = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      sda_t_n = 1'b1;
      cnt_n   = '0;
      full_n  = 1'b0;
    end else begin
      case (state)
        ADDR, WR_DATA: begin
          // full marks 8 bits in; cnt has already wrapped to 0.
          if (scl_rise && !full) begin
            shift_n = {shift[6:0], sda};
            cnt_n   = cnt + 3'd1;
            full_n  = (cnt == 3'd7);
          end else if (scl_fall && full) begin
            full_n = 1'b0;
            if (state == WR_DATA) begin
              rx_data_n  = shift;
              rx_valid_n = 1'b1;
              rx_first_n = first;
              first_n    = 1'b0;
              sda_t_n    = 1'b0;
              state_n    = WR_ACK;
            end else if (shift[7:1] == IIC_ADDR) begin
              sda_t_n = 1'b0;
              rnw_n   = shift[0];
              busy_n  = 1'b1;
              state_n = ADDR_ACK;
            end else begin
              sda_t_n = 1'b1;
              state_n = WAIT_STOP;
            end
          end
        end
        ADDR_ACK, RD_ACK: begin
          if (state == RD_ACK && scl_rise && sda) begin
            state_n = WAIT_STOP;
          end else if (scl_fall) begin
            cnt_n = '0;
            if (state == ADDR_ACK && !rnw) begin
              sda_t_n = 1'b1;
              first_n = 1'b1;
              state_n = WR_DATA;
            end else begin
              shift_n    = bus.tx_data;
              tx_taken_n = 1'b1;
              sda_t_n    = bus.tx_data[7];
              state_n    = RD_DATA;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_t_n = 1'b1;
            state_n = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              sda_t_n = 1'b1;
              state_n = RD_ACK;
            end else begin
              shift_n = {shift[6:0], 1'b0};
              sda_t_n = shift[6];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_o    = 1'b0;
  assign bus.sda_t    = sda_t;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_first = rx_first;
  assign bus.tx_taken = tx_taken;
  assign bus.busy     = busy;
  assign bus.stop_det = stop_det;
endmodule

// File: tb/tb_kat_iic_slave.sv
// tb_kat_iic_slave: bit-banged I2C master driving kat_iic_slave,
// rx bytes checked against a scoreboard queue.
module tb_kat_iic_slave;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic sda_line;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int tx_cnt = 0;
  int stop_cnt = 0;
  int low_cnt = 0;
  int busy_cyc = 0;
  int busy_falls = 0;
  logic busy_prev = 1'b0;

  kat_iic_slave_if bus();

  assign sda_line    = m_sda & (bus.sda_t ? 1'b1 : bus.sda_o);
  assign bus.scl_i   = m_scl;
  assign bus.sda_i   = sda_line;
  assign bus.tx_data = tx_data;

  kat_iic_slave dut (
    .OPB_Clk (clk),
    .OPB_Rst (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid) obs_q.push_back({bus.rx_first, bus.rx_data});
    if (bus.tx_taken) tx_cnt++;
    if (bus.stop_det) stop_cnt++;
    if (!bus.sda_t) low_cnt++;
    if (bus.busy) busy_cyc++;
    if (busy_prev && !bus.busy) busy_falls++;
    busy_prev = bus.busy;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b1; qwait();
  endtask

  task automatic bit_io(input logic b, output logic s);
    m_sda = b; qwait();
    m_scl = 1'b1; qwait();
    s = sda_line; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b,
                           output logic rel);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      b[i] = s;
    end
    m_sda = mack; qwait();
    m_scl = 1'b1; qwait();
    rel = bus.sda_t; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic write_data(string tag, input logic [7:0] b,
                            input logic first);
    logic ack;
    exp_q.push_back({first, b});
    send_byte(b, ack);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_rx"}, obs_q.size() != 0 ? 32'(obs_q.pop_front()) :
        32'hDEAD, 32'(exp_q.pop_front()));
  endtask

  initial begin
    logic ack, rel;
    logic [7:0] rb;
    int s0, t0, l0, b0, f0;

    repeat (3) @(negedge clk);
    chk("rst_sda_t", 32'(bus.sda_t), 32'd1);
    chk("rst_sda_o", 32'(bus.sda_o), 32'd0);
    chk("rst_rx", {22'd0, bus.rx_first, bus.rx_valid, bus.rx_data},
        32'd0);
    chk("rst_flags", {29'd0, bus.tx_taken, bus.busy, bus.stop_det},
        32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // write 0x78, 0x0F
    s0 = stop_cnt;
    i2c_start();
    send_byte(8'h52, ack);
    chk("wr_addr_ack", 32'(ack), 32'd0);
    write_data("wr_b0", 8'h78, 1'b1);
    write_data("wr_b1", 8'h0F, 1'b0);
    chk("wr_busy", 32'(bus.busy), 32'd1);
    i2c_stop();
    qwait();
    chk("wr_stop_det", 32'(stop_cnt - s0), 32'd1);
    chk("wr_busy_end", 32'(bus.busy), 32'd0);

    // address mismatch
    s0 = stop_cnt; l0 = low_cnt; b0 = busy_cyc;
    i2c_start();
    send_byte(8'h30, ack);
    chk("mm_addr_nack", 32'(ack), 32'd1);
    send_byte(8'hAA, ack);
    chk("mm_data_nack", 32'(ack), 32'd1);
    i2c_stop();
    qwait();
    chk("mm_sda_low", 32'(low_cnt - l0), 32'd0);
    chk("mm_busy", 32'(busy_cyc - b0), 32'd0);
    chk("mm_no_rx", 32'(obs_q.size()), 32'd0);
    chk("mm_stop_det", 32'(stop_cnt - s0), 32'd1);

    // read two bytes of 0xC3
    tx_data = 8'hC3;
    t0 = tx_cnt;
    i2c_start();
    send_byte(8'h53, ack);
    chk("rd_addr_ack", 32'(ack), 32'd0);
    read_byte(1'b0, rb, rel);
    chk("rd_b0", 32'(rb), 32'hC3);
    chk("rd_b0_rel", 32'(rel), 32'd1);
    read_byte(1'b1, rb, rel);
    chk("rd_b1", 32'(rb), 32'hC3);
    chk("rd_b1_rel", 32'(rel), 32'd1);
    i2c_stop();
    qwait();
    chk("rd_taken", 32'(tx_cnt - t0), 32'd2);
    chk("rd_busy_end", 32'(bus.busy), 32'd0);

    // repeated START: write 0x11 then read 0x5A
    tx_data = 8'h5A;
    i2c_start();
    send_byte(8'h52, ack);
    chk("rs_wr_ack", 32'(ack), 32'd0);
    write_data("rs_wr", 8'h11, 1'b1);
    f0 = busy_falls;
    i2c_start();
    send_byte(8'h53, ack);
    chk("rs_rd_ack", 32'(ack), 32'd0);
    read_byte(1'b1, rb, rel);
    chk("rs_rd", 32'(rb), 32'h5A);
    chk("rs_busy", 32'(bus.busy), 32'd1);
    chk("rs_busy_cont", 32'(busy_falls - f0), 32'd0);
    i2c_stop();
    qwait();
    chk("rs_busy_end", 32'(bus.busy), 32'd0);
    chk("rs_no_extra_rx", 32'(obs_q.size()), 32'd0);

    // STOP after 4 data bits
    s0 = stop_cnt;
    i2c_start();
    send_byte(8'h52, ack);
    chk("ab_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) bit_io(i[0], ack);
    i2c_stop();
    qwait();
    chk("ab_no_rx", 32'(obs_q.size()), 32'd0);
    chk("ab_rx_hold", 32'(bus.rx_data), 32'h11);
    chk("ab_stop_det", 32'(stop_cnt - s0), 32'd1);
    chk("ab_busy", 32'(bus.busy), 32'd0);

    // reset while SDA is driven low during a read
    tx_data = 8'h00;
    i2c_start();
    send_byte(8'h53, ack);
    chk("rr_addr_ack", 32'(ack), 32'd0);
    chk("rr_sda_low", 32'(bus.sda_t), 32'd0);
    rst = 1'b1;
    #1;
    chk("rr_sda_rel", 32'(bus.sda_t), 32'd1);
    m_sda = 1'b1;
    m_scl = 1'b1;
    repeat (4) @(negedge clk);
    chk("rr_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    i2c_start();
    send_byte(8'h52, ack);
    chk("rr_wr_ack", 32'(ack), 32'd0);
    write_data("rr_wr", 8'hA5, 1'b1);
    i2c_stop();
    qwait();
    chk("rr_busy_end", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
